// File: rtl/am_arb_pkg.sv
// Shared types and constants for the AM port arbiter.
// No logic; imported by am_port_arbiter.
// Default starvation limit sets the default counter width.
package am_arb_pkg;

    localparam int STARVE_LIMIT_DEF = 8;
    localparam int STARVE_W         = $clog2(STARVE_LIMIT_DEF + 1);

    typedef enum logic [1:0] {REQ_NONE, REQ_WB, REQ_HOST, REQ_SRCH} am_req_e;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} am_arb_state_e;

endpackage

// File: rtl/am_port_arbiter.sv
// Arbitrates the single-port AM SRAM between encoder write-back, host preload and search reads.
// Latency: grants and AM pins are combinational; search read data returns 1 cycle after its grant.
// Backpressure: losers see gnt=0 and hold req; a search burst locks out writes until the starvation limit.
module am_port_arbiter
    import am_arb_pkg::*;
#(
    parameter int HV_LENGTH     = 2048,
    parameter int AM_ADDR_WIDTH = 13,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     soft_reset_i,
    input  logic                     wb_req_i,
    input  logic [AM_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [HV_LENGTH-1:0]     wb_wdata_i,
    output logic                     wb_gnt_o,
    input  logic                     host_req_i,
    input  logic [AM_ADDR_WIDTH-1:0] host_addr_i,
    input  logic [HV_LENGTH-1:0]     host_wdata_i,
    output logic                     host_gnt_o,
    input  logic                     srch_req_i,
    input  logic [AM_ADDR_WIDTH-1:0] srch_addr_i,
    input  logic                     srch_last_i,
    output logic                     srch_gnt_o,
    output logic                     srch_rvalid_o,
    output logic [HV_LENGTH-1:0]     srch_rdata_o,
    output logic [AM_ADDR_WIDTH-1:0] am_addr_o,
    output logic                     am_ren_o,
    output logic                     am_wen_o,
    output logic [HV_LENGTH-1:0]     am_wdata_o,
    input  logic [HV_LENGTH-1:0]     am_rdata_i,
    output logic                     busy_o
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    am_arb_state_e    state_q;
    logic [CNT_W-1:0] starve_q;
    logic             rvalid_q;
    am_req_e          sel;
    logic             starved;

    assign starved = (starve_q == CNT_MAX);

    // Grants are gated by the raw reset so nothing reaches the macro while reset is asserted.
    always_comb begin
        sel = REQ_NONE;
        if (rst_ni && !soft_reset_i) begin
            if (state_q == ARB_IDLE) begin
                if (wb_req_i)        sel = REQ_WB;
                else if (host_req_i) sel = REQ_HOST;
                else if (srch_req_i) sel = REQ_SRCH;
            end else begin
                if (starved && wb_req_i)        sel = REQ_WB;
                else if (starved && host_req_i) sel = REQ_HOST;
                else if (srch_req_i)            sel = REQ_SRCH;
            end
        end
    end

    assign wb_gnt_o   = (sel == REQ_WB);
    assign host_gnt_o = (sel == REQ_HOST);
    assign srch_gnt_o = (sel == REQ_SRCH);
    assign am_ren_o   = srch_gnt_o;
    assign am_wen_o   = wb_gnt_o | host_gnt_o;

    always_comb begin
        am_addr_o  = '0;
        am_wdata_o = '0;
        case (sel)
            REQ_WB: begin
                am_addr_o  = wb_addr_i;
                am_wdata_o = wb_wdata_i;
            end
            REQ_HOST: begin
                am_addr_o  = host_addr_i;
                am_wdata_o = host_wdata_i;
            end
            REQ_SRCH: am_addr_o = srch_addr_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
            rvalid_q <= 1'b0;
        end else if (soft_reset_i) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= srch_gnt_o;
            if (srch_gnt_o) begin
                state_q <= srch_last_i ? ARB_IDLE : ARB_LOCKED;
            end
            if (wb_gnt_o || host_gnt_o) begin
                starve_q <= '0;
            end else if (state_q == ARB_LOCKED && (wb_req_i || host_req_i) && !starved) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end

    assign srch_rvalid_o = rvalid_q;
    assign srch_rdata_o  = rvalid_q ? am_rdata_i : '0;
    assign busy_o        = (state_q == ARB_LOCKED) | rvalid_q;

endmodule
